// File: rtl/ps2_frame_rx.sv
// ---------------------------------------------------------------------------
// ps2_frame_rx
//
// Deserialises one 11-bit keyboard frame (start, 8 data bits LSB first,
// parity, stop) from the synchronised serial lines. The frame is checked and
// the byte is presented with a one-cycle strobe. Everything runs on CLK. The
// serial clock is sampled, and its falling edge is detected from the samples.
//
// Parameters:
//   TIMEOUT_CYC : CLK cycles without a serial-clock fall before an open frame
//                 is abandoned
//   ODD_PARITY  : 1 = odd parity over data+parity, 0 = even
//
// Ports:
//   CLK    in   system clock, rising edge
//   RST_N  in   synchronous active-low reset
//   sSCL   in   synchronised serial clock (idle high)
//   sSDA   in   synchronised serial data  (idle high)
//   START  in   frame-active flag from the start/control circuit
//   DATA   out  last correctly received byte
//   VALID  out  one-cycle pulse, DATA just updated
//   PERR   out  one-cycle pulse, parity mismatch (frame dropped)
//   FERR   out  one-cycle pulse, framing error (stop, START lost, timeout)
//   BUSY   out  frame in progress, up to and including the result pulse
// ---------------------------------------------------------------------------
module ps2_frame_rx #(
    parameter int TIMEOUT_CYC = 5000,
    parameter int ODD_PARITY  = 1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       sSCL,
    input  logic       sSDA,
    input  logic       START,
    output logic [7:0] DATA,
    output logic       VALID,
    output logic       PERR,
    output logic       FERR,
    output logic       BUSY
);

    localparam int            TW      = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC - 1);
    localparam logic          PAR_ODD = (ODD_PARITY != 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          scl_q;
    logic [3:0]    cnt_q,   cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q,   par_d;
    logic [TW-1:0] tmo_q,   tmo_d;
    logic [7:0]    data_q,  data_d;
    logic          valid_q, valid_d;
    logic          perr_q,  perr_d;
    logic          ferr_q,  ferr_d;
    logic          fall;

    // One cycle per high-to-low transition of the sampled serial clock.
    assign fall = scl_q & ~sSCL;

    always_comb begin
        // NOTE: every signal gets a default before the case statement, so no
        // path leaves one unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        par_d   = par_q;
        data_d  = data_q;
        valid_d = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;

        // The watchdog only runs while a frame is open. Any fall restarts it.
        if (fall || state_q == ST_IDLE) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (fall && !sSDA) begin
                    state_d = ST_DATA;
                    cnt_d   = 4'd0;
                end
            end

            ST_DATA: begin
                if (fall) begin
                    if (!START) begin
                        state_d = ST_IDLE;
                        ferr_d  = 1'b1;
                    end else begin
                        shift_d[cnt_q[2:0]] = sSDA;
                        cnt_d               = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            state_d = ST_PARITY;
                        end
                    end
                end
            end

            ST_PARITY: begin
                if (fall) begin
                    if (!START) begin
                        state_d = ST_IDLE;
                        ferr_d  = 1'b1;
                    end else begin
                        par_d   = sSDA;
                        state_d = ST_STOP;
                    end
                end
            end

            ST_STOP: begin
                // START is deliberately not checked on the stop-bit fall.
                if (fall) begin
                    state_d = ST_IDLE;
                    if (!sSDA) begin
                        ferr_d = 1'b1;
                    end else if ((^{shift_q, par_q}) != PAR_ODD) begin
                        perr_d = 1'b1;
                    end else begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // A fall in the same cycle as expiry takes priority over the abort.
        if (state_q != ST_IDLE && !fall && tmo_q == TMO_MAX) begin
            state_d = ST_IDLE;
            ferr_d  = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!RST_N) begin
            state_q <= ST_IDLE;
            scl_q   <= 1'b1;
            cnt_q   <= 4'd0;
            shift_q <= 8'h00;
            par_q   <= 1'b0;
            tmo_q   <= '0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            scl_q   <= sSCL;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tmo_q   <= tmo_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign DATA  = data_q;
    assign VALID = valid_q;
    assign PERR  = perr_q;
    assign FERR  = ferr_q;
    // The result pulse lands in the cycle the state is already back in IDLE.
    // That cycle still counts as busy.
    assign BUSY  = (state_q != ST_IDLE) | valid_q | perr_q | ferr_q;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// ---------------------------------------------------------------------------
// tb_ps2_frame_rx
//
// Bench for ps2_frame_rx. A table of whole frames is checked against expected
// outcomes written as constants. Hand sequences cover timeout, reset
// mid-frame and back-to-back frames. Randomised frames are then applied.
// On every cycle, all outputs are compared with a frame-level reference
// model. The model keeps the received bits in a queue and the idle time as a
// plain counter.
// ---------------------------------------------------------------------------
module tb_ps2_frame_rx;

    localparam int T_CYC = 64;
    localparam bit ODD   = 1'b1;

    logic       CLK;
    logic       RST_N;
    logic       sSCL;
    logic       sSDA;
    logic       START;
    logic [7:0] DATA;
    logic       VALID;
    logic       PERR;
    logic       FERR;
    logic       BUSY;

    ps2_frame_rx #(.TIMEOUT_CYC(T_CYC), .ODD_PARITY(1)) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .sSCL (sSCL),
        .sSDA (sSDA),
        .START(START),
        .DATA (DATA),
        .VALID(VALID),
        .PERR (PERR),
        .FERR (FERR),
        .BUSY (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Pulses observed since the last clear, used by the frame-level checks.
    int n_valid, n_perr, n_ferr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit         m_active;
    bit         m_q[$];
    int         m_gap;
    logic [7:0] m_data;
    bit         m_prev_scl;
    bit         e_valid, e_perr, e_ferr;

    task automatic model_step(input logic rst, input logic scl, input logic sda, input logic st);
        int  ones;
        bit  fall;
        e_valid = 0;
        e_perr  = 0;
        e_ferr  = 0;
        fall    = m_prev_scl && !scl;
        if (!rst) begin
            m_active = 0;
            m_q.delete();
            m_gap    = 0;
            m_data   = 8'h00;
        end else if (fall) begin
            m_gap = 0;
            if (!m_active) begin
                if (!sda) begin
                    m_active = 1;
                    m_q.delete();
                end
            end else if (m_q.size() < 9 && !st) begin
                m_active = 0;
                e_ferr   = 1;
            end else begin
                m_q.push_back(sda);
                if (m_q.size() == 10) begin
                    m_active = 0;
                    ones = 0;
                    for (int i = 0; i < 9; i++) ones += m_q[i];
                    if (!sda) begin
                        e_ferr = 1;
                    end else if ((ones % 2 == 1) != ODD) begin
                        e_perr = 1;
                    end else begin
                        for (int i = 0; i < 8; i++) m_data[i] = m_q[i];
                        e_valid = 1;
                    end
                end
            end
        end else if (m_active) begin
            m_gap++;
            if (m_gap == T_CYC) begin
                m_active = 0;
                e_ferr   = 1;
            end
        end
        m_prev_scl = rst ? scl : 1'b1;
    endtask

    // Apply one cycle of inputs, then compare every output after the edge.
    task automatic step(input logic rst, input logic scl, input logic sda, input logic st);
        RST_N = rst;
        sSCL  = scl;
        sSDA  = sda;
        START = st;
        model_step(rst, scl, sda, st);
        @(posedge CLK);
        #1;
        cyc++;
        check("cyc_valid", 32'(VALID), 32'(e_valid));
        check("cyc_perr",  32'(PERR),  32'(e_perr));
        check("cyc_ferr",  32'(FERR),  32'(e_ferr));
        check("cyc_busy",  32'(BUSY),  32'(m_active | e_valid | e_perr | e_ferr));
        check("cyc_data",  32'(DATA),  32'(m_data));
        n_valid += int'(VALID);
        n_perr  += int'(PERR);
        n_ferr  += int'(FERR);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic clear_counts();
        n_valid = 0;
        n_perr  = 0;
        n_ferr  = 0;
    endtask

    // Send the first nbits of a frame, using half cycles high then half cycles
    // low for each bit. START is raised from the first data bit. From bit
    // index drop_at onwards (when drop_at >= 0), START is held low instead.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                              input int drop_at, input int nbits, input int half);
        logic [10:0] bits;
        logic        st;
        bits = {stp, par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            st = (i >= 1) && !(drop_at >= 0 && i >= drop_at);
            repeat (half) step(1'b1, 1'b1, bits[i], st);
            repeat (half) step(1'b1, 1'b0, bits[i], st);
        end
        RST_N = 1'b1;
        sSDA  = 1'b1;
    endtask

    typedef struct {
        logic [7:0] d;
        logic       par;
        logic       stp;
        int         drop_at;
        int         nbits;
        int         ev, ep, ef;
        logic [7:0] edata;
    } vec_t;

    vec_t       vecs[9];
    logic [7:0] rd;
    logic       rpar, rstp;
    int         rdrop, rnb, rhalf;

    initial begin
        m_prev_scl = 1'b1;
        m_data     = 8'h00;
        clear_counts();

        //            d      par   stp   drop nb  v  p  f  data
        vecs[0] = '{8'h1C, 1'b0, 1'b1, -1, 11, 1, 0, 0, 8'h1C};
        vecs[1] = '{8'h1C, 1'b1, 1'b1, -1, 11, 0, 1, 0, 8'h1C};
        vecs[2] = '{8'hF0, 1'b1, 1'b0, -1, 11, 0, 0, 1, 8'h1C};
        vecs[3] = '{8'hF0, 1'b1, 1'b1, -1, 11, 1, 0, 0, 8'hF0};
        vecs[4] = '{8'h1C, 1'b0, 1'b1,  5,  6, 0, 0, 1, 8'hF0};
        vecs[5] = '{8'h1C, 1'b0, 1'b1, -1, 11, 1, 0, 0, 8'h1C};
        vecs[6] = '{8'h00, 1'b1, 1'b1, -1, 11, 1, 0, 0, 8'h00};
        vecs[7] = '{8'hFF, 1'b1, 1'b1, -1, 11, 1, 0, 0, 8'hFF};
        vecs[8] = '{8'hFF, 1'b0, 1'b1, -1, 11, 0, 1, 0, 8'hFF};

        // Reset state
        repeat (2) step(1'b0, 1'b1, 1'b1, 1'b0);
        check("rst_data",  32'(DATA),  32'h00);
        check("rst_busy",  32'(BUSY),  32'h0);
        check("rst_valid", 32'(VALID), 32'h0);
        idle(3);

        // Frame table
        foreach (vecs[k]) begin
            clear_counts();
            send_frame(vecs[k].d, vecs[k].par, vecs[k].stp, vecs[k].drop_at, vecs[k].nbits, 3);
            idle(4);
            check($sformatf("vec%0d_valid", k), 32'(n_valid), 32'(vecs[k].ev));
            check($sformatf("vec%0d_perr", k),  32'(n_perr),  32'(vecs[k].ep));
            check($sformatf("vec%0d_ferr", k),  32'(n_ferr),  32'(vecs[k].ef));
            check($sformatf("vec%0d_data", k),  32'(DATA),    32'(vecs[k].edata));
            check($sformatf("vec%0d_busy", k),  32'(BUSY),    32'h0);
        end

        // Timeout: start bit plus 4 data bits, then the clock stays high
        clear_counts();
        send_frame(8'h1C, 1'b0, 1'b1, -1, 5, 3);
        idle(T_CYC + 5);
        check("tmo_ferr", 32'(n_ferr), 32'd1);
        check("tmo_busy", 32'(BUSY),   32'h0);
        clear_counts();
        send_frame(8'hF0, 1'b1, 1'b1, -1, 11, 3);
        idle(3);
        check("tmo_next_valid", 32'(n_valid), 32'd1);
        check("tmo_next_data",  32'(DATA),    32'hF0);

        // Reset after the 3rd data bit: silent discard, outputs cleared
        clear_counts();
        send_frame(8'hA5, 1'b1, 1'b1, -1, 4, 3);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        check("mid_rst_data", 32'(DATA), 32'h00);
        check("mid_rst_busy", 32'(BUSY), 32'h0);
        idle(T_CYC + 5);
        check("mid_rst_pulses", 32'(n_valid + n_perr + n_ferr), 32'd0);
        clear_counts();
        send_frame(8'h1C, 1'b0, 1'b1, -1, 11, 3);
        idle(3);
        check("mid_rst_next_valid", 32'(n_valid), 32'd1);
        check("mid_rst_next_data",  32'(DATA),    32'h1C);

        // Back-to-back frames at the fastest clock rate
        clear_counts();
        send_frame(8'h5A, 1'b1, 1'b1, -1, 11, 1);
        send_frame(8'h3C, 1'b1, 1'b1, -1, 11, 1);
        idle(3);
        check("b2b_valid", 32'(n_valid), 32'd2);
        check("b2b_data",  32'(DATA),    32'h3C);

        // Randomised frames, checked cycle by cycle against the model
        for (int f = 0; f < 60; f++) begin
            rd    = 8'($urandom);
            rpar  = ~(^rd);
            if ($urandom_range(0, 3) == 0) rpar = ~rpar;
            rstp  = ($urandom_range(0, 7) != 0);
            rdrop = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 10)) : -1;
            rnb   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 10)) : 11;
            rhalf = int'($urandom_range(1, 4));
            send_frame(rd, rpar, rstp, rdrop, rnb, rhalf);
            if (rnb < 11) idle(T_CYC + 5);
            else          idle(int'($urandom_range(1, 6)));
        end
        idle(T_CYC + 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
